// File: rtl/fifo_ring.sv
// fifo_ring: parametrised circular-buffer FIFO with show-ahead output.
// Words stay where they were written; only the read/write pointers move.
// Status flags are decoded from a registered occupancy count, and two
// sticky error flags record dropped pushes and pops issued while empty.
module fifo_ring #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             push,
    input  logic             pop,
    input  logic             clear_err,
    output logic [WIDTH-1:0] out_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic acc_push;
    logic acc_pop;

    // Status decodes of the count register, plus which requests are honoured.
    // A push into a full queue is only accepted when a pop frees the head slot.
    always_comb begin
        empty       = (count_reg == '0);
        full        = (count_reg == DEPTH_CNT);
        almost_full = (count_reg >= AF_CNT);
        acc_push    = push && (!full || pop);
        acc_pop     = pop && !empty;
    end

    // Next-state: pointers wrap at DEPTH-1 (DEPTH need not be a power of two),
    // count tracks net movement, and error flags are sticky with set beating clear.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg + CW'(acc_push) - CW'(acc_pop);
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (acc_push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + AW'(1);
        end
        if (acc_pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + AW'(1);
        end

        if (clear_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (push && !acc_push) begin
            overflow_next = 1'b1;
        end
        if (pop && empty) begin
            underflow_next = 1'b1;
        end
    end

    // Control state register; reset overrides all requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (!reset && acc_push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Show-ahead head word, forced to zero while the queue is empty.
    assign out_data  = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: scenario tasks plus a randomized run, all checked against a
// queue-based reference model of the FIFO rules.
module tb_fifo_ring;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clear_err = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    fifo_ring #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .push(push),
        .pop(pop),
        .clear_err(clear_err),
        .out_data(out_data),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle of requests, apply the FIFO rules to the model at the
    // edge, and return 1 time unit later so outputs can be sampled.
    task automatic step(input bit p, input bit o, input logic [WIDTH-1:0] d,
                        input bit c, input bit r);
        bit was_full;
        bit was_empty;
        bit ap;
        bit ao;
        push = p; pop = o; in_data = d; clear_err = c; reset = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            ap = p && (!was_full || o);
            ao = o && !was_empty;
            if (ao) void'(mq.pop_front());
            if (ap) mq.push_back(d);
            if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (p && was_full && !o) m_ovf = 1'b1;
            if (o && was_empty) m_unf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", out_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got=%b exp=0", underflow); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(i), 0, 0);
            n_tests++; if (count !== 4'(i)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            n_tests++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i >= 6)); end
            n_tests++; if (full !== (i == 8)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 8)); end
            n_tests++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL fill_head i=%0d got=%h exp=01", i, out_data); end
            $display("[TB] push %02h count=%0d af=%b full=%b", i, count, almost_full, full);
        end
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (out_data !== 8'(i)) begin n_fail++; $display("FAIL drain_out i=%0d got=%h exp=%02h", i, out_data, i); end
            $display("[TB] pop  %02h", out_data);
            step(0, 1, 8'h00, 0, 0);
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL drain_out_zero got=%h exp=00", out_data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) step(1, 0, 8'h11 + 8'(i), 0, 0);
        step(1, 0, 8'hAA, 0, 0);
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", count); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_tests++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL ovf_head got=%h exp=11", out_data); end
        step(0, 0, 8'h00, 1, 0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        step(1, 0, 8'hCC, 1, 0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        step(0, 0, 8'h00, 1, 0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2 got=%b exp=0", overflow); end
        $display("[TB] test_overflow done count=%0d", count);
    endtask

    task automatic test_full_pushpop();
        logic [WIDTH-1:0] exp_v;
        step(1, 1, 8'hBB, 0, 0);
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_count got=%0d exp=8", count); end
        n_tests++; if (out_data !== 8'h12) begin n_fail++; $display("FAIL fpp_head got=%h exp=12", out_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
        for (int k = 0; k < 8; k++) begin
            exp_v = (k < 7) ? 8'h12 + 8'(k) : 8'hBB;
            n_tests++; if (out_data !== exp_v) begin n_fail++; $display("FAIL fpp_drain k=%0d got=%h exp=%h", k, out_data, exp_v); end
            $display("[TB] pop  %02h", out_data);
            step(0, 1, 8'h00, 0, 0);
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d;
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            step(1, 1, d, 0, 0);
            n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL wrap_count i=%0d got=%0d exp=3", i, count); end
            n_tests++; if (out_data !== exp_head()) begin n_fail++; $display("FAIL wrap_out i=%0d got=%h exp=%h", i, out_data, exp_head()); end
            $display("[TB] wrap push %02h head=%02h", d, out_data);
        end
    endtask

    task automatic test_underflow_reset();
        step(0, 0, 8'h00, 0, 1);
        step(1, 1, 8'h5C, 0, 0);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got=%b exp=1", underflow); end
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL unf_count got=%0d exp=1", count); end
        n_tests++; if (out_data !== 8'h5C) begin n_fail++; $display("FAIL unf_out got=%h exp=5c", out_data); end
        step(1, 0, 8'h77, 0, 0);
        step(1, 0, 8'h88, 0, 1);
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_unf got=%b exp=0", underflow); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        n_tests++; if (empty !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL rst_empty got=%b/%h exp=1/00", empty, out_data); end
        $display("[TB] test_underflow_reset done");
    endtask

    task automatic test_random();
        bit p, o, c, r;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(99) < 60);
            o = ($urandom_range(99) < 50);
            c = ($urandom_range(99) < 8);
            r = ($urandom_range(99) < 2);
            step(p, o, 8'($urandom), c, r);
            n_tests++; if (out_data !== exp_head()) begin n_fail++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, out_data, exp_head()); end
            n_tests++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
            n_tests++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty i=%0d got=%b", i, empty); end
            n_tests++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full i=%0d got=%b", i, full); end
            n_tests++; if (almost_full !== (mq.size() >= AF_LEVEL)) begin n_fail++; $display("FAIL rnd_af i=%0d got=%b", i, almost_full); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, overflow, m_ovf); end
            n_tests++; if (underflow !== m_unf) begin n_fail++; $display("FAIL rnd_unf i=%0d got=%b exp=%b", i, underflow, m_unf); end
            $display("[TB] rnd %0d p=%b o=%b c=%b r=%b count=%0d head=%02h", i, p, o, c, r, count, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_pushpop();
        test_wrap();
        test_underflow_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
